// File: rtl/arm_command_scheduler_if.sv
// Avalon-MM slave bus bundle between the host and the arm command scheduler.
interface arm_command_scheduler_if;
  logic [4:0]  address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (output address, write, read, writedata, input readdata, waitrequest);
  modport slave  (input address, write, read, writedata, output readdata, waitrequest);
endinterface

// File: rtl/arm_command_scheduler.sv
// Register front end for the arm I2C controller: staged hand frames committed atomically to shadows,
// done-handshaked write_hand / elbow read requests, periodic angle poll, sticky ack/timeout flags.
module arm_command_scheduler #(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int DEFAULT_PERIOD = 500000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  arm_command_scheduler_if.slave    avs,
  input  logic                      done,
  input  logic [11:0]               angle,
  input  logic                      ack_error,
  output logic                      elbow_read_joint_angle,
  output logic                      write_hand,
  output logic [6:0]                elbow_device_id,
  output logic [6:0]                arm_board_device_id_0,
  output logic [6:0]                arm_board_device_id_1,
  output logic [6:0]                arm_board_device_id_2,
  output logic [6:0]                arm_board_device_id_3,
  output logic [87:0]               arm_board_commandFrame_0,
  output logic [87:0]               arm_board_commandFrame_1,
  output logic [87:0]               arm_board_commandFrame_2,
  output logic [87:0]               arm_board_commandFrame_3
);
  localparam int NUM_BOARDS = 4;

  typedef enum logic [2:0] {IDLE, LOAD, REQ_W, WAIT_W, REQ_R, WAIT_R} state_t;

  logic [NUM_BOARDS-1:0][87:0] stg_frame, shd_frame;
  logic [NUM_BOARDS-1:0][6:0]  stg_id, shd_id;
  logic [6:0]  stg_elbow, shd_elbow;
  logic        poll_enable;
  logic [31:0] period, period_eff, timer, tcnt;
  logic [11:0] angle_reg;
  logic        ack_err_sticky, timeout_sticky, commit_pending, read_pending;
  logic        busy, in_xfer, timed_out, poll_tick, wr_ctrl, wr_stat, rd_clr;
  logic [31:0] rdata;
  state_t      state;

  assign busy       = (state != IDLE);
  assign in_xfer    = (state == REQ_W) || (state == WAIT_W) || (state == REQ_R) || (state == WAIT_R);
  assign timed_out  = in_xfer && (tcnt == 32'(TIMEOUT_CYCLES - 1));
  assign period_eff = (period == 32'd0) ? 32'd1 : period;
  assign poll_tick  = poll_enable && (timer == 32'd0);
  assign wr_ctrl    = avs.write && (avs.address == 5'd14);
  assign wr_stat    = avs.write && (avs.address == 5'd16);
  assign rd_clr     = ((state == WAIT_R) && done) || (((state == REQ_R) || (state == WAIT_R)) && timed_out);

  // Host-side register file; staging stays writable regardless of FSM state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stg_frame   <= '0;
      stg_id      <= '0;
      stg_elbow   <= '0;
      poll_enable <= 1'b0;
      period      <= 32'(DEFAULT_PERIOD);
    end else if (avs.write) begin
      for (int b = 0; b < NUM_BOARDS; b++) begin
        if (avs.address == 5'(3*b))     stg_frame[b][31:0]  <= avs.writedata;
        if (avs.address == 5'(3*b + 1)) stg_frame[b][63:32] <= avs.writedata;
        if (avs.address == 5'(3*b + 2)) stg_frame[b][87:64] <= avs.writedata[23:0];
        if (avs.address == 5'd12)       stg_id[b]           <= avs.writedata[8*b +: 7];
      end
      if (avs.address == 5'd13) stg_elbow   <= avs.writedata[6:0];
      if (avs.address == 5'd14) poll_enable <= avs.writedata[0];
      if (avs.address == 5'd15) period      <= avs.writedata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer          <= 32'(DEFAULT_PERIOD);
      commit_pending <= 1'b0;
      read_pending   <= 1'b0;
      ack_err_sticky <= 1'b0;
      timeout_sticky <= 1'b0;
    end else begin
      if (!poll_enable || poll_tick) timer <= period_eff;
      else                           timer <= timer - 32'd1;
      // New requests win over same-cycle clears so a fresh commit/poll is never swallowed.
      commit_pending <= (commit_pending && (state != LOAD)) || (wr_ctrl && avs.writedata[1]);
      read_pending   <= (read_pending && !rd_clr) || poll_tick || (wr_ctrl && avs.writedata[2]);
      ack_err_sticky <= (ack_err_sticky && !(wr_stat && avs.writedata[17])) || (ack_error && busy);
      timeout_sticky <= (timeout_sticky && !(wr_stat && avs.writedata[18])) || timed_out;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= IDLE;
      write_hand             <= 1'b0;
      elbow_read_joint_angle <= 1'b0;
      shd_frame              <= '0;
      shd_id                 <= '0;
      shd_elbow              <= '0;
      angle_reg              <= '0;
      tcnt                   <= '0;
    end else begin
      tcnt <= tcnt + 32'd1;
      case (state)
        IDLE: if (done) begin
          if (commit_pending) state <= LOAD;
          else if (read_pending) begin
            state                  <= REQ_R;
            elbow_read_joint_angle <= 1'b1;
            tcnt                   <= '0;
          end
        end
        LOAD: begin
          shd_frame  <= stg_frame;
          shd_id     <= stg_id;
          shd_elbow  <= stg_elbow;
          write_hand <= 1'b1;
          tcnt       <= '0;
          state      <= REQ_W;
        end
        REQ_W: if (timed_out || !done) begin
          write_hand <= 1'b0;
          state      <= timed_out ? IDLE : WAIT_W;
        end
        WAIT_W: if (timed_out || done) state <= IDLE;
        REQ_R: if (timed_out || !done) begin
          elbow_read_joint_angle <= 1'b0;
          state                  <= timed_out ? IDLE : WAIT_R;
        end
        WAIT_R: if (timed_out) state <= IDLE;
          else if (done) begin
            angle_reg <= angle;
            state     <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (avs.read) begin
      for (int b = 0; b < NUM_BOARDS; b++) begin
        if (avs.address == 5'(3*b))     rdata = stg_frame[b][31:0];
        if (avs.address == 5'(3*b + 1)) rdata = stg_frame[b][63:32];
        if (avs.address == 5'(3*b + 2)) rdata = {8'h00, stg_frame[b][87:64]};
      end
      case (avs.address)
        5'd12: rdata = {1'b0, stg_id[3], 1'b0, stg_id[2], 1'b0, stg_id[1], 1'b0, stg_id[0]};
        5'd13: rdata = {25'd0, stg_elbow};
        5'd14: rdata = {31'd0, poll_enable};
        5'd15: rdata = period;
        5'd16: rdata = {11'd0, read_pending, commit_pending, timeout_sticky, ack_err_sticky, busy,
                        4'd0, angle_reg};
        default: ;
      endcase
    end
  end

  assign avs.readdata              = rdata;
  assign avs.waitrequest           = 1'b0;
  assign elbow_device_id           = shd_elbow;
  assign arm_board_device_id_0     = shd_id[0];
  assign arm_board_device_id_1     = shd_id[1];
  assign arm_board_device_id_2     = shd_id[2];
  assign arm_board_device_id_3     = shd_id[3];
  assign arm_board_commandFrame_0  = shd_frame[0];
  assign arm_board_commandFrame_1  = shd_frame[1];
  assign arm_board_commandFrame_2  = shd_frame[2];
  assign arm_board_commandFrame_3  = shd_frame[3];
endmodule

// File: tb/tb_arm_command_scheduler.sv
// Directed bench: host bus tasks, auto-responding downstream model, request-order scoreboard.
module tb_arm_command_scheduler;
  localparam int TO = 200;
  localparam int DP = 300;

  typedef struct packed {
    bit               wr;
    logic [3:0][87:0] f;
    logic [3:0][6:0]  id;
    logic [6:0]       e;
  } txn_t;

  logic clock = 1'b0, reset_n = 1'b0;
  logic auto_done, man_done = 1'b1, use_manual = 1'b0, auto_resp = 1'b1;
  logic [11:0] angle, resp_angle = 12'h3C7;
  logic ack_error = 1'b0;
  logic done;
  logic elbow_read_joint_angle, write_hand;
  logic [6:0]  elbow_device_id, id0, id1, id2, id3;
  logic [87:0] fr0, fr1, fr2, fr3;

  int n_vec = 0, n_err = 0, cyc = 0;
  logic poll_mode = 1'b0;
  txn_t sb[$];
  logic [3:0][87:0] m_f = '0;
  logic [3:0][6:0]  m_id = '0;
  logic [6:0]       m_e = '0;

  arm_command_scheduler_if bus();
  assign done = use_manual ? man_done : auto_done;

  arm_command_scheduler #(.TIMEOUT_CYCLES(TO), .DEFAULT_PERIOD(DP)) dut (
    .clock(clock), .reset_n(reset_n), .avs(bus.slave), .done(done), .angle(angle),
    .ack_error(ack_error), .elbow_read_joint_angle(elbow_read_joint_angle), .write_hand(write_hand),
    .elbow_device_id(elbow_device_id), .arm_board_device_id_0(id0), .arm_board_device_id_1(id1),
    .arm_board_device_id_2(id2), .arm_board_device_id_3(id3), .arm_board_commandFrame_0(fr0),
    .arm_board_commandFrame_1(fr1), .arm_board_commandFrame_2(fr2), .arm_board_commandFrame_3(fr3));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [351:0] obs, input logic [351:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    @(posedge clock); #1;
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(posedge clock); #1;
    bus.address = a; bus.read = 1'b1;
    #1 d = bus.readdata;
    bus.read = 1'b0;
  endtask

  task automatic set_frame(input int b, input logic [87:0] v);
    bus_write(5'(3*b), v[31:0]);
    bus_write(5'(3*b + 1), v[63:32]);
    bus_write(5'(3*b + 2), {8'hA5, v[87:64]});
    m_f[b] = v;
  endtask

  task automatic set_ids(input logic [3:0][6:0] ids, input logic [6:0] e);
    bus_write(5'd12, {1'b1, ids[3], 1'b1, ids[2], 1'b1, ids[1], 1'b1, ids[0]});
    bus_write(5'd13, {25'h1FFFFFF, e});
    m_id = ids; m_e = e;
  endtask

  function automatic txn_t snap(input bit wr);
    txn_t t;
    t.wr = wr; t.f = m_f; t.id = m_id; t.e = m_e;
    return t;
  endfunction

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    bit ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      bus_read(5'd16, s);
      if (!s[16] && !s[19] && !s[20] && sb.size() == 0) begin ok = 1'b1; break; end
    end
    check(tag, ok, 1'b1);
  endtask

  task automatic wait_high(input string tag, input bit is_wr);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if ((is_wr ? write_hand : elbow_read_joint_angle) === 1'b1) begin ok = 1'b1; break; end
    end
    check(tag, ok, 1'b1);
  endtask

  // Downstream model: drop done a couple of cycles after a request, return it with the angle later.
  initial begin
    auto_done = 1'b1; angle = '0;
    forever begin
      @(posedge clock); #1;
      if (auto_resp && !use_manual && (write_hand || elbow_read_joint_angle)) begin
        repeat (2) @(posedge clock);
        #1 auto_done = 1'b0;
        repeat (4) @(posedge clock);
        #1 angle = resp_angle; auto_done = 1'b1;
      end
    end
  end

  // Scoreboard consumer: every request rising edge must match the next expected transaction.
  logic pw = 1'b0, pr = 1'b0, have_last = 1'b0;
  int last_rd = 0;
  txn_t t;
  always @(negedge clock) begin
    if (write_hand === 1'b1 && !pw) begin
      check("both_high_w", elbow_read_joint_angle, 1'b0);
      if (sb.size() == 0) check("unexpected_w", 1'b1, 1'b0);
      else begin
        t = sb.pop_front();
        check("kind_w", 1'b1, t.wr);
        check("shadow_frames", {fr3, fr2, fr1, fr0}, t.f);
        check("shadow_ids", {id3, id2, id1, id0, elbow_device_id}, {t.id, t.e});
      end
    end
    if (elbow_read_joint_angle === 1'b1 && !pr) begin
      check("both_high_r", write_hand, 1'b0);
      if (sb.size() == 0) check("unexpected_r", 1'b1, 1'b0);
      else begin
        t = sb.pop_front();
        check("kind_r", 1'b0, t.wr);
      end
      if (poll_mode && have_last) check("poll_interval", (cyc - last_rd) >= 98 && (cyc - last_rd) <= 104, 1'b1);
      last_rd = cyc; have_last = poll_mode;
    end
    if (!poll_mode) have_last = 1'b0;
    pw = write_hand; pr = elbow_read_joint_angle;
  end

  initial begin
    logic [31:0] r;
    txn_t held;
    bus.address = '0; bus.write = 1'b0; bus.read = 1'b0; bus.writedata = '0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_write_hand", write_hand, 1'b0);
    check("rst_elbow_req", elbow_read_joint_angle, 1'b0);
    check("rst_frames", {fr3, fr2, fr1, fr0}, 352'd0);
    check("rst_ids", {id3, id2, id1, id0, elbow_device_id}, 35'd0);
    check("waitrequest", bus.waitrequest, 1'b0);
    bus.address = 5'd15;
    #1 check("readdata_idle", bus.readdata, 32'd0);
    bus_read(5'd16, r); check("rst_status", r, 32'd0);
    bus_read(5'd15, r); check("rst_period", r, 32'(DP));
    bus_read(5'd14, r); check("rst_ctrl", r, 32'd0);
    @(negedge clock) reset_n = 1'b1;

    bus_write(5'd2, 32'hFFFF_FFFF);
    bus_read(5'd2, r); check("w2_upper_zero", r, 32'h00FF_FFFF);
    bus_read(5'd20, r); check("unmapped_read", r, 32'd0);
    bus_write(5'd21, 32'hDEAD_BEEF);

    // Basic commit.
    for (int b = 0; b < 4; b++) set_frame(b, {$urandom, $urandom, $urandom});
    set_ids({7'h33, 7'h22, 7'h11, 7'h05}, 7'h4C);
    bus_read(5'd12, r); check("id_readback", r, {1'b0, 7'h33, 1'b0, 7'h22, 1'b0, 7'h11, 1'b0, 7'h05});
    bus_read(5'd4, r); check("stage_readback", r, m_f[1][63:32]);
    sb.push_back(snap(1'b1));
    bus_write(5'd14, 32'h2);
    wait_idle("commit_idle");
    check("shadow_after", {fr3, fr2, fr1, fr0}, m_f);

    // Commit and read_now in the same write: write first, then read.
    set_frame(2, {$urandom, $urandom, $urandom});
    sb.push_back(snap(1'b1));
    sb.push_back(snap(1'b0));
    bus_write(5'd14, 32'h6);
    wait_idle("both_idle");
    bus_read(5'd16, r); check("angle_3c7", r[11:0], 12'h3C7);

    // Staging edits during an in-flight write must not reach the shadows.
    set_frame(0, 88'h0123_4567_89AB_CDEF_0011_22);
    held = snap(1'b1);
    sb.push_back(held);
    bus_write(5'd14, 32'h2);
    wait_high("inflight_req", 1'b1);
    set_frame(0, 88'hFEDC_BA98_7654_3210_FFEE_DD);
    wait_idle("inflight_idle");
    check("shadow_held", fr0, held.f[0]);
    sb.push_back(snap(1'b1));
    bus_write(5'd14, 32'h2);
    wait_idle("recommit_idle");
    check("shadow_new", fr0, 88'hFEDC_BA98_7654_3210_FFEE_DD);

    // Periodic poll.
    resp_angle = 12'h5A3;
    poll_mode = 1'b1;
    bus_write(5'd15, 32'd100);
    for (int i = 0; i < 3; i++) sb.push_back(snap(1'b0));
    bus_write(5'd14, 32'h1);
    for (int k = 0; k < 1000 && sb.size() != 0; k++) @(negedge clock);
    check("poll_count", sb.size(), 0);
    bus_write(5'd14, 32'h0);
    poll_mode = 1'b0;
    wait_idle("poll_idle");
    bus_read(5'd16, r); check("angle_5a3", r[11:0], 12'h5A3);

    // Timeout: downstream never acknowledges.
    auto_resp = 1'b0;
    sb.push_back(snap(1'b0));
    bus_write(5'd14, 32'h4);
    wait_high("to_req", 1'b0);
    repeat (TO - 20) @(negedge clock);
    check("to_still_req", elbow_read_joint_angle, 1'b1);
    bus_read(5'd16, r); check("to_not_yet", r[18], 1'b0);
    repeat (30) @(negedge clock);
    check("to_req_dropped", elbow_read_joint_angle, 1'b0);
    bus_read(5'd16, r); check("to_status", r[20:16], 5'b00100);
    bus_write(5'd16, 32'h0004_0000);
    bus_read(5'd16, r); check("to_w1c", r[18], 1'b0);
    auto_resp = 1'b1;

    // Ack error only counts while busy.
    @(negedge clock) ack_error = 1'b1;
    @(negedge clock) ack_error = 1'b0;
    bus_read(5'd16, r); check("ackerr_idle", r[17], 1'b0);
    sb.push_back(snap(1'b0));
    bus_write(5'd14, 32'h4);
    wait_high("ack_req", 1'b0);
    ack_error = 1'b1;
    @(negedge clock) ack_error = 1'b0;
    wait_idle("ack_idle");
    bus_read(5'd16, r); check("ackerr_set", r[17], 1'b1);
    bus_write(5'd16, 32'h0002_0000);
    bus_read(5'd16, r); check("ackerr_w1c", r[17], 1'b0);

    // Async reset while waiting for write completion.
    use_manual = 1'b1; man_done = 1'b1;
    sb.push_back(snap(1'b1));
    bus_write(5'd14, 32'h2);
    wait_high("rst_req", 1'b1);
    man_done = 1'b0;
    for (int k = 0; k < 20 && write_hand === 1'b1; k++) @(negedge clock);
    check("rst_wait_w", write_hand, 1'b0);
    @(negedge clock) reset_n = 1'b0;
    #1;
    check("mid_rst_req", {write_hand, elbow_read_joint_angle}, 2'b00);
    check("mid_rst_frames", {fr3, fr2, fr1, fr0}, 352'd0);
    check("mid_rst_ids", {id3, id2, id1, id0, elbow_device_id}, 35'd0);
    bus_read(5'd16, r); check("mid_rst_status", r, 32'd0);
    @(negedge clock) reset_n = 1'b1;
    man_done = 1'b1; use_manual = 1'b0;
    m_f = '0; m_id = '0; m_e = '0;
    bus_read(5'd15, r); check("post_rst_period", r, 32'(DP));
    set_frame(3, {$urandom, $urandom, $urandom});
    set_ids({7'h7F, 7'h01, 7'h40, 7'h2A}, 7'h15);
    sb.push_back(snap(1'b1));
    bus_write(5'd14, 32'h2);
    wait_idle("resume_idle");
    check("resume_frames", {fr3, fr2, fr1, fr0}, m_f);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
